mul_unpack: RTL and testbench
=============================

MUL_UNPACK -- requirements
Module: mul_unpack

Interface
REQ-001 SHALL have parameters: SIGN_W, default 1, sign field width; EXPO_W, default 8, exponent field width; MANT_W, default 23, stored fraction width.
REQ-002 SHALL have ports, one per line, as name, direction, width, meaning:
- clk  input  1  single clock, all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  SIGN_W+EXPO_W+MANT_W  IEEE operand A.
- in_b  input  SIGN_W+EXPO_W+MANT_W  IEEE operand B.
- out_valid  output  1  unpacked result valid.
- out_ready  input  1  downstream accepts the result.
- sign_1  output  1  sign(A) XOR sign(B).
- expo_a  output  EXPO_W+2  signed biased exponent of A.
- expo_b  output  EXPO_W+2  signed biased exponent of B.
- mant_a  output  MANT_W+1  normalized significand of A, hidden bit included.
- mant_b  output  MANT_W+1  normalized significand of B, hidden bit included.
- a_is_n0  output  1  A is nonzero.
- b_is_n0  output  1  B is nonzero.
- a_is_inf  output  1  A is infinity.
- b_is_inf  output  1  B is infinity.
- a_is_nan  output  1  A is NaN.
- b_is_nan  output  1  B is NaN.

Function
REQ-003 SHALL implement three states: IDLE, NORM and OUT.
REQ-004 SHALL drive in_ready = (state==IDLE) | (state==OUT & out_ready).
REQ-005 SHALL accept an operand pair when in_valid & in_ready.
REQ-006 On accept, SHALL register both operands and their classification flags.
REQ-007 SHALL classify each operand as follows:
- zero: exp==0, frac==0.
- subnormal: exp==0, frac!=0.
- inf: exp all-ones, frac==0.
- NaN: exp all-ones, frac!=0.
REQ-008 Normal operand: SHALL set expo = zero-extended exp field and mant = {1,frac}.
REQ-009 Zero operand: SHALL set expo = 0, mant = 0 and is_n0 = 0.
REQ-010 Inf or NaN operand: SHALL set expo = zero-extended exp field and mant = {0,frac}, with the inf/nan flag set and is_n0 = 1.
REQ-011 Subnormal operand: SHALL load expo = 1 and mant = {0,frac}.
REQ-012 Each NORM cycle, for each operand whose mant[MANT_W]==0 and mant!=0, SHALL shift mant left by 1 and decrement expo by 1 (two's complement, EXPO_W+2 bits).
REQ-013 SHALL go from IDLE or OUT to NORM on accept when either operand is subnormal; otherwise to OUT.
REQ-014 SHALL go from NORM to OUT in the cycle in which both operands have mant[MANT_W]==1 or mant==0.
REQ-015 SHALL spend at most MANT_W cycles in NORM.
REQ-016 Latency, accept edge T to out_valid: T+1 for non-subnormal pairs; T+1+k for subnormal pairs, where k = max leading-zero shift count over both operands.
REQ-017 SHALL hold out_valid=1 and all outputs stable in OUT until out_ready=1.
REQ-018 On OUT & out_ready & !in_valid, SHALL return to IDLE.
REQ-019 On OUT & out_ready & in_valid, SHALL accept the new pair in the same cycle, with no bubble.
REQ-020 SHALL keep out_valid=0 in IDLE and NORM.
REQ-021 SHALL ignore in_valid while in NORM (in_ready=0).
REQ-022 Outputs SHALL come directly from registers, with no combinational path from in_a/in_b to any output.

Reset
REQ-023 On rst=1 at a clock edge, state SHALL become IDLE.
REQ-024 On rst=1 at a clock edge, out_valid, sign_1, expo_a/b, mant_a/b and all flags SHALL become 0.
REQ-025 rst SHALL take priority over accept, shift and handshake events.
REQ-026 rst asserted in NORM or OUT SHALL discard the in-flight pair.
REQ-027 After rst deasserts, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-028 SHALL use macro MUL_UNPACK_DAZ_EN.
REQ-029 When MUL_UNPACK_DAZ_EN is defined, SHALL treat subnormal operands as zero (expo=0, mant=0, is_n0=0), keep the original sign, omit the NORM state and give fixed latency 1.
REQ-030 When MUL_UNPACK_DAZ_EN is undefined, SHALL implement full subnormal normalization per REQ-011..REQ-016.

Verification (EXPO_W=8, MANT_W=23)
REQ-031 SHALL cover: in_a=0x3F800000, in_b=0xC0000000, out_ready=1 -> cycle T+1: out_valid=1, sign_1=1, expo_a=127, expo_b=128, mant_a=mant_b=0x800000, a_is_n0=b_is_n0=1.
REQ-032 SHALL cover: in_a=0x00000001, in_b=0x00400000 -> out_valid at T+24, expo_a=0x3EA (-22), mant_a=0x800000, expo_b=0, mant_b=0x800000; in_ready=0 during T+1..T+23.
REQ-033 SHALL cover: in_a=0x00000000, in_b=0x7F800000 -> T+1: a_is_n0=0, mant_a=0, b_is_inf=1, b_is_nan=0. Also in_a=0x7FC00000 -> a_is_nan=1.
REQ-034 SHALL cover: out_ready=0 for 5 cycles in OUT with new pair pending -> outputs stable, in_ready=0; out_ready=1 -> next pair accepted the same cycle, its out_valid one cycle later.
REQ-035 SHALL cover: rst=1 during NORM of in_a=0x00000001 -> next cycle out_valid=0, in_ready=1, all outputs 0.
REQ-036 SHALL cover, with MUL_UNPACK_DAZ_EN defined: in_a=0x80000001 -> T+1: a_is_n0=0, mant_a=0, expo_a=0, sign preserved in sign_1.

Source files
------------

// File: rtl/mul_unpack.sv
// Unpacks an IEEE operand pair for a multiplier: classifies, splits fields and normalizes subnormals.
// Optional macro MUL_UNPACK_DAZ_EN flushes subnormals to zero and removes the NORM state.

module mul_unpack_lane #(
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_load,
  input  logic                     i_norm,
  input  logic [EXPO_W+MANT_W-1:0] i_op,
  output logic                     o_sub,
  output logic                     o_done,
  output logic [EXPO_W+1:0]        o_expo,
  output logic [MANT_W:0]          o_mant,
  output logic                     o_n0,
  output logic                     o_inf,
  output logic                     o_nan
);
  localparam logic [EXPO_W+1:0] EXPO_ONE = {{(EXPO_W+1){1'b0}}, 1'b1};

  logic [EXPO_W-1:0] w_exp;
  logic [MANT_W-1:0] w_frac;
  logic              w_exp_zero, w_exp_ones, w_frac_nz;
  logic [EXPO_W+1:0] w_ld_expo, w_expo_nx;
  logic [MANT_W:0]   w_ld_mant, w_mant_nx;
  logic              w_ld_n0, w_ld_inf, w_ld_nan, w_shift;
  logic [EXPO_W+1:0] r_expo;
  logic [MANT_W:0]   r_mant;
  logic              r_n0, r_inf, r_nan;

  assign w_exp      = i_op[EXPO_W+MANT_W-1:MANT_W];
  assign w_frac     = i_op[MANT_W-1:0];
  assign w_exp_zero = (w_exp == '0);
  assign w_exp_ones = &w_exp;
  assign w_frac_nz  = |w_frac;

`ifdef MUL_UNPACK_DAZ_EN
  assign o_sub = 1'b0;
`else
  assign o_sub = w_exp_zero & w_frac_nz;
`endif

  always_comb begin
    w_ld_expo = {2'b00, w_exp};
    w_ld_mant = {1'b1, w_frac};
    w_ld_n0   = 1'b1;
    w_ld_inf  = 1'b0;
    w_ld_nan  = 1'b0;
    if (w_exp_zero) begin
      if (o_sub) begin
        // subnormal starts at the minimum exponent and is normalized later
        w_ld_expo = EXPO_ONE;
        w_ld_mant = {1'b0, w_frac};
      end else begin
        w_ld_expo = '0;
        w_ld_mant = '0;
        w_ld_n0   = 1'b0;
      end
    end else if (w_exp_ones) begin
      w_ld_mant = {1'b0, w_frac};
      w_ld_inf  = ~w_frac_nz;
      w_ld_nan  = w_frac_nz;
    end
  end

  assign w_shift   = i_norm & ~r_mant[MANT_W] & (|r_mant);
  assign w_mant_nx = w_shift ? {r_mant[MANT_W-1:0], 1'b0} : r_mant;
  assign w_expo_nx = w_shift ? (r_expo - EXPO_ONE) : r_expo;
  // status after this cycle's shift, so NORM can exit on the final shift edge
  assign o_done    = w_mant_nx[MANT_W] | ~(|w_mant_nx);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_expo <= '0;
      r_mant <= '0;
      r_n0   <= 1'b0;
      r_inf  <= 1'b0;
      r_nan  <= 1'b0;
    end else if (i_load) begin
      r_expo <= w_ld_expo;
      r_mant <= w_ld_mant;
      r_n0   <= w_ld_n0;
      r_inf  <= w_ld_inf;
      r_nan  <= w_ld_nan;
    end else begin
      r_expo <= w_expo_nx;
      r_mant <= w_mant_nx;
    end
  end

  assign o_expo = r_expo;
  assign o_mant = r_mant;
  assign o_n0   = r_n0;
  assign o_inf  = r_inf;
  assign o_nan  = r_nan;
endmodule

module mul_unpack #(
  parameter int SIGN_W = 1,
  parameter int EXPO_W = 8,
  parameter int MANT_W = 23
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0] in_a,
  input  logic [SIGN_W+EXPO_W+MANT_W-1:0] in_b,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            sign_1,
  output logic [EXPO_W+1:0]               expo_a,
  output logic [EXPO_W+1:0]               expo_b,
  output logic [MANT_W:0]                 mant_a,
  output logic [MANT_W:0]                 mant_b,
  output logic                            a_is_n0,
  output logic                            b_is_n0,
  output logic                            a_is_inf,
  output logic                            b_is_inf,
  output logic                            a_is_nan,
  output logic                            b_is_nan
);
  localparam int W = SIGN_W + EXPO_W + MANT_W;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_NORM = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]                     r_state, w_state_nx;
  logic                           r_out_valid, r_sign;
  logic                           w_in_ready, w_accept, w_norm, w_any_sub;
  logic [1:0]                     w_sub, w_done, w_n0, w_inf, w_nan;
  logic [1:0][EXPO_W+MANT_W-1:0]  w_op;
  logic [1:0][EXPO_W+1:0]         w_expo;
  logic [1:0][MANT_W:0]           w_mant;

  assign w_op[0] = in_a[EXPO_W+MANT_W-1:0];
  assign w_op[1] = in_b[EXPO_W+MANT_W-1:0];

  assign w_in_ready = (r_state == S_IDLE) | ((r_state == S_OUT) & out_ready);
  assign w_accept   = in_valid & w_in_ready;
  assign w_norm     = (r_state == S_NORM);
  assign w_any_sub  = |w_sub;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    mul_unpack_lane #(.EXPO_W(EXPO_W), .MANT_W(MANT_W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_accept),
      .i_norm (w_norm),
      .i_op   (w_op[g]),
      .o_sub  (w_sub[g]),
      .o_done (w_done[g]),
      .o_expo (w_expo[g]),
      .o_mant (w_mant[g]),
      .o_n0   (w_n0[g]),
      .o_inf  (w_inf[g]),
      .o_nan  (w_nan[g])
    );
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nx = w_any_sub ? S_NORM : S_OUT;
      S_NORM: if (&w_done) w_state_nx = S_OUT;
      S_OUT: begin
        if (out_ready) begin
          if (in_valid) w_state_nx = w_any_sub ? S_NORM : S_OUT;
          else          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_sign      <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_out_valid <= (w_state_nx == S_OUT);
      if (w_accept) r_sign <= in_a[W-1] ^ in_b[W-1];
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign sign_1    = r_sign;
  assign expo_a    = w_expo[0];
  assign expo_b    = w_expo[1];
  assign mant_a    = w_mant[0];
  assign mant_b    = w_mant[1];
  assign a_is_n0   = w_n0[0];
  assign b_is_n0   = w_n0[1];
  assign a_is_inf  = w_inf[0];
  assign b_is_inf  = w_inf[1];
  assign a_is_nan  = w_nan[0];
  assign b_is_nan  = w_nan[1];
endmodule

// File: tb/tb_mul_unpack.sv
// Bench for mul_unpack: arithmetic reference model, per-cycle compare, directed corner cases, random traffic.
module tb_mul_unpack;
  typedef struct packed {
    logic        sign;
    logic [9:0]  ea, eb;
    logic [23:0] ma, mb;
    logic        an0, bn0, ainf, binf, anan, bnan;
  } res_t;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1;
  logic [31:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid, sign_1;
  logic [9:0]  expo_a, expo_b;
  logic [23:0] mant_a, mant_b;
  logic        a_is_n0, b_is_n0, a_is_inf, b_is_inf, a_is_nan, b_is_nan;

  int n_checks = 0, n_fail = 0;
  bit started = 1'b0;

  mul_unpack #(.SIGN_W(1), .EXPO_W(8), .MANT_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .sign_1(sign_1), .expo_a(expo_a), .expo_b(expo_b), .mant_a(mant_a), .mant_b(mant_b),
    .a_is_n0(a_is_n0), .b_is_n0(b_is_n0), .a_is_inf(a_is_inf), .b_is_inf(b_is_inf),
    .a_is_nan(a_is_nan), .b_is_nan(b_is_nan)
  );

  always #5 clk = ~clk;

  res_t got;
  assign got = {sign_1, expo_a, expo_b, mant_a, mant_b,
                a_is_n0, b_is_n0, a_is_inf, b_is_inf, a_is_nan, b_is_nan};

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: fields from IEEE rules; subnormal pairs normalize every unnormalized nonzero mantissa.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, output int k);
    logic [31:0] op[2];
    logic [7:0]  ex;
    logic [22:0] fr;
    int          e[2];
    longint      m[2];
    bit          sub[2], n0[2], inf[2], nan[2];
    res_t        r;
    op[0] = a; op[1] = b; k = 0;
    for (int i = 0; i < 2; i++) begin
      ex = op[i][30:23]; fr = op[i][22:0];
      n0[i] = 1; inf[i] = 0; nan[i] = 0; sub[i] = 0;
      if (ex == 0 && fr == 0) begin e[i] = 0; m[i] = 0; n0[i] = 0; end
      else if (ex == 0) begin
`ifdef MUL_UNPACK_DAZ_EN
        e[i] = 0; m[i] = 0; n0[i] = 0;
`else
        e[i] = 1; m[i] = longint'(fr); sub[i] = 1;
`endif
      end
      else if (ex == 8'hFF) begin e[i] = 255; m[i] = longint'(fr); inf[i] = (fr == 0); nan[i] = (fr != 0); end
      else begin e[i] = int'(ex); m[i] = longint'(fr) + (64'd1 << 23); end
    end
    if (sub[0] || sub[1])
      for (int i = 0; i < 2; i++) begin
        int s = 0;
        while (m[i] != 0 && m[i] < (64'd1 << 23)) begin m[i] = m[i] * 2; e[i] = e[i] - 1; s++; end
        if (s > k) k = s;
      end
    r.sign = a[31] ^ b[31];
    r.ea = 10'(e[0]); r.eb = 10'(e[1]);
    r.ma = 24'(m[0]); r.mb = 24'(m[1]);
    r.an0 = n0[0]; r.bn0 = n0[1]; r.ainf = inf[0]; r.binf = inf[1]; r.anan = nan[0]; r.bnan = nan[1];
    return r;
  endfunction

  // Transaction-level model: pending result, remaining normalize cycles, result-valid flag.
  res_t nr, m_res = '0;
  int   nk, m_cnt = 0;
  bit   m_valid = 1'b0;
  logic exp_rdy;
  always_comb nr = model(in_a, in_b, nk);
  assign exp_rdy = (m_cnt == 0) && (!m_valid || out_ready);

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0; m_cnt <= 0; m_res <= '0;
    end else if (in_valid && exp_rdy) begin
      m_res <= nr; m_cnt <= nk; m_valid <= (nk == 0);
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_valid <= 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("in_ready", 128'(in_ready), 128'(exp_rdy));
      chk("out_valid", 128'(out_valid), 128'(m_valid));
      if (m_valid) chk("result", 128'(got), 128'(m_res));
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rnd_op();
    logic [31:0] r;
    logic [22:0] f;
    logic [7:0]  e;
    int c;
    r = $urandom; c = $urandom_range(0, 9);
    f = r[22:0];
    e = r[30:23];
    case (c)
      0: begin e = 8'h00; f = '0; end
      1, 2: begin e = 8'h00; f = f >> $urandom_range(0, 22); if (f == 0) f = 23'd1; end
      3: begin e = 8'hFF; f = '0; end
      4: begin e = 8'hFF; if (f == 0) f = 23'd5; end
      default: if (e == 8'h00 || e == 8'hFF) e = 8'h80;
    endcase
    return {r[31], e, f};
  endfunction

  initial begin
    res_t mr;
    int   mk;
    // model pins
    mr = model(32'h00000001, 32'h00400000, mk);
    chk("model_sub_k", 128'(mk), 128'(23));
    chk("model_sub_ea", 128'(mr.ea), 128'(10'h3EA));
    chk("model_sub_mb", 128'({mr.eb, mr.mb}), 128'({10'h000, 24'h800000}));
    mr = model(32'h3F800000, 32'hC0000000, mk);
    chk("model_norm", 128'({mr.sign, mr.ea, mr.eb, mr.ma}), 128'({1'b1, 10'd127, 10'd128, 24'h800000}));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0; started = 1'b1;
    @(negedge clk);
    chk("reset_ready", 128'({in_ready, out_valid}), 128'(2'b10));
    chk("reset_outs", 128'(got), 128'(0));

    issue(32'h3F800000, 32'hC0000000);
    chk("norm_pair", 128'({out_valid, sign_1, expo_a, expo_b, mant_a, mant_b, a_is_n0, b_is_n0}),
        128'({1'b1, 1'b1, 10'd127, 10'd128, 24'h800000, 24'h800000, 1'b1, 1'b1}));

`ifndef MUL_UNPACK_DAZ_EN
    issue(32'h00000001, 32'h00400000);
    for (int c = 1; c <= 24; c++) begin
      if (c < 24) chk("norm_busy", 128'({in_ready, out_valid}), 128'(2'b00));
      else chk("sub_pair", 128'({out_valid, expo_a, mant_a, expo_b, mant_b}),
               128'({1'b1, 10'h3EA, 24'h800000, 10'h000, 24'h800000}));
      if (c < 24) @(negedge clk);
    end
`else
    issue(32'h80000001, 32'h3F800000);
    chk("daz_pair", 128'({out_valid, sign_1, a_is_n0, expo_a, mant_a}),
        128'({1'b1, 1'b1, 1'b0, 10'h000, 24'h000000}));
`endif

    issue(32'h00000000, 32'h7F800000);
    chk("zero_inf", 128'({a_is_n0, mant_a, b_is_inf, b_is_nan}), 128'({1'b0, 24'h0, 1'b1, 1'b0}));
    issue(32'h7FC00000, 32'h3F800000);
    chk("nan_a", 128'({a_is_nan, a_is_inf, a_is_n0}), 128'(3'b101));

    // stall in OUT with a second pair waiting
    @(posedge clk); #1;
    in_a = 32'h3F800000; in_b = 32'h3F800000; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1 in_a = 32'h40400000; in_b = 32'h40000000;
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", 128'({in_ready, out_valid, expo_a, mant_a}), 128'({1'b0, 1'b1, 10'd127, 24'h800000}));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("no_bubble", 128'({out_valid, expo_a, mant_a, expo_b}), 128'({1'b1, 10'd128, 24'hC00000, 10'd128}));

    // reset in the middle of a transaction
    issue(32'h00000001, 32'h3F800000);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid", 128'({out_valid, in_ready, got}), 128'({1'b0, 1'b1, 75'd0}));

    repeat (3000) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_a      = rnd_op();
      in_b      = rnd_op();
    end
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
